// File: rtl/nf_axis_chk_pkg.sv
// Shared definitions for the AXI4-Stream packet checker.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, per-packet context struct, LFSR seed/taps,
// tuser length-field bounds and error-counter saturation value.
package nf_axis_chk_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,     // waiting for the first beat of a packet
        ST_BODY = 1'b1      // inside a multi-beat packet
    } chk_state_t;

    // Packet length travels in tuser[15:0] on the first beat.
    localparam int TUSER_LEN_LSB = 0;
    localparam int TUSER_LEN_MSB = 15;

    localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11. Right-shifting form:
    // those taps land on bits 0,2,3,5 of the current state.
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    // Context carried from one beat of a packet to the next.
    typedef struct packed {
        logic [15:0] len_exp;   // length latched from the first beat
        logic [15:0] byte_off;  // bytes accepted so far in this packet
        logic        data_bad;  // a payload/keep error has been seen
    } pkt_ctx_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAP_MASK), s[15:1]};
    endfunction

endpackage

// File: rtl/nf_axis_keep_count.sv
// tkeep analysis: byte count (popcount) plus contiguity and all-ones flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; stateless.
//
// Ports: keep (lane enables, LSB = byte 0) -> byte_cnt, contig (keep is a
// run of ones starting at bit 0, including all-zero), all_ones.
module nf_axis_keep_count
    import nf_axis_chk_pkg::*;
#(
    parameter int KEEP_W = 8,
    parameter int CNT_W  = $clog2(KEEP_W + 1)
) (
    input  logic [KEEP_W-1:0] keep,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              contig,
    output logic              all_ones
);

    logic [KEEP_W-1:0] keep_p1;

    // A value of the form 0..01..1 has no bit in common with itself + 1.
    assign keep_p1  = keep + {{(KEEP_W-1){1'b0}}, 1'b1};
    assign contig   = ((keep & keep_p1) == '0);
    assign all_ones = &keep;

    always_comb begin
        byte_cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            byte_cnt = byte_cnt + CNT_W'(keep[i]);
        end
    end

endmodule

// File: rtl/nf_axis_pkt_checker.sv
// AXI4-Stream test-pattern checker: verifies length and byte pattern, counts packets/errors.
// Latency: counters, err_sticky and done update on the clock edge that accepts the tlast beat.
// Backpressure: tready=1 out of reset, or LFSR-driven random stalls when CHK_BACKPRESSURE_EN is defined.
//
// Ports: axis_aclk/axis_reset (sync, active-high); s_axis_* AXI4-Stream slave
// (tuser[15:0] = packet length on the first beat); expected_pkts = packets in
// the run; pkt_cnt, err_len_cnt, err_data_cnt, err_sticky, done = status.
// Build option: CHK_BACKPRESSURE_EN.
// Payload byte k of a packet must equal (pkt_cnt[7:0] + k) mod 256.
module nf_axis_pkt_checker
    import nf_axis_chk_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 64,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNT_WIDTH          = 32
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    input  logic [C_CNT_WIDTH-1:0]            expected_pkts,
    output logic [C_CNT_WIDTH-1:0]            pkt_cnt,
    output logic [15:0]                       err_len_cnt,
    output logic [15:0]                       err_data_cnt,
    output logic                              err_sticky,
    output logic                              done
);

    localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;
    localparam int KCNT_W = $clog2(KEEP_W + 1);

    chk_state_t       state;
    pkt_ctx_t         ctx;

    logic             beat_acc;
    logic [KCNT_W-1:0] keep_cnt;
    logic             keep_contig;
    logic             keep_full;

    logic             first_beat;
    logic [15:0]      off;
    logic [15:0]      len_cur;
    logic [15:0]      byte_tot;
    logic [7:0]       exp_b;
    logic             beat_bad;
    logic             pkt_data_bad;
    logic             pkt_len_bad;
    logic [C_CNT_WIDTH-1:0] pkt_cnt_nxt;

    // Only the length field of tuser is meaningful here.
    logic             unused_tuser;
    assign unused_tuser = ^s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:TUSER_LEN_MSB+1];

    assign beat_acc = s_axis_tvalid & s_axis_tready;

    nf_axis_keep_count #(
        .KEEP_W (KEEP_W),
        .CNT_W  (KCNT_W)
    ) u_keep_count (
        .keep     (s_axis_tkeep),
        .byte_cnt (keep_cnt),
        .contig   (keep_contig),
        .all_ones (keep_full)
    );

    // Per-beat evaluation. On the first beat the packet context is taken
    // straight from the bus (offset 0, length from tuser) so that a
    // single-beat packet needs no extra cycle.
    always_comb begin
        first_beat = (state == ST_IDLE);
        off        = first_beat ? 16'd0 : ctx.byte_off;
        len_cur    = first_beat ? s_axis_tuser[TUSER_LEN_MSB:TUSER_LEN_LSB] : ctx.len_exp;
        beat_bad   = !keep_contig || (!s_axis_tlast && !keep_full);
        exp_b      = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            exp_b = pkt_cnt[7:0] + off[7:0] + 8'(i);
            if (s_axis_tkeep[i] && (s_axis_tdata[8*i +: 8] != exp_b)) begin
                beat_bad = 1'b1;
            end
        end
        pkt_data_bad = (!first_beat && ctx.data_bad) || beat_bad;
        byte_tot     = off + 16'(keep_cnt);
        pkt_len_bad  = (byte_tot != len_cur);
        pkt_cnt_nxt  = pkt_cnt + C_CNT_WIDTH'(beat_acc & s_axis_tlast);
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state        <= ST_IDLE;
            ctx          <= '0;
            pkt_cnt      <= '0;
            err_len_cnt  <= '0;
            err_data_cnt <= '0;
            err_sticky   <= 1'b0;
            done         <= 1'b0;
        end else begin
            pkt_cnt <= pkt_cnt_nxt;
            // Evaluated against the next count so done moves with pkt_cnt.
            done    <= (pkt_cnt_nxt == expected_pkts) && (expected_pkts != '0);
            if (beat_acc) begin
                if (s_axis_tlast) begin
                    state <= ST_IDLE;
                    ctx   <= '0;
                    if (pkt_len_bad && (err_len_cnt != ERR_CNT_MAX)) begin
                        err_len_cnt <= err_len_cnt + 16'd1;
                    end
                    if (pkt_data_bad && (err_data_cnt != ERR_CNT_MAX)) begin
                        err_data_cnt <= err_data_cnt + 16'd1;
                    end
                    if (pkt_len_bad || pkt_data_bad) begin
                        err_sticky <= 1'b1;
                    end
                end else begin
                    state        <= ST_BODY;
                    ctx.len_exp  <= len_cur;
                    ctx.byte_off <= byte_tot;
                    ctx.data_bad <= pkt_data_bad;
                end
            end
        end
    end

`ifdef CHK_BACKPRESSURE_EN
    logic [15:0] lfsr;

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Seed bit 0 is 1, so the reset term is what keeps tready low in reset.
    assign s_axis_tready = !axis_reset && lfsr[0];
`else
    assign s_axis_tready = !axis_reset;
`endif

endmodule

// File: tb/tb_nf_axis_pkt_checker.sv
module tb_nf_axis_pkt_checker;

    logic          axis_aclk = 1'b0;
    logic          axis_reset = 1'b1;
    logic [63:0]   s_axis_tdata = '0;
    logic [7:0]    s_axis_tkeep = '0;
    logic [127:0]  s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic [31:0]   expected_pkts = '0;
    logic [31:0]   pkt_cnt;
    logic [15:0]   err_len_cnt;
    logic [15:0]   err_data_cnt;
    logic          err_sticky;
    logic          done;

    always #5 axis_aclk = ~axis_aclk;

    nf_axis_pkt_checker dut (
        .axis_aclk     (axis_aclk),
        .axis_reset    (axis_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .expected_pkts (expected_pkts),
        .pkt_cnt       (pkt_cnt),
        .err_len_cnt   (err_len_cnt),
        .err_data_cnt  (err_data_cnt),
        .err_sticky    (err_sticky),
        .done          (done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: expected status after each counted packet.
    typedef struct {
        logic [31:0] cnt;
        logic [15:0] el;
        logic [15:0] ed;
        logic        st;
        logic        dn;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_cnt = '0;
    logic [15:0] m_el = '0;
    logic [15:0] m_ed = '0;
    logic        m_st = 1'b0;
    logic        gaps = 1'b0;

    task automatic model_reset();
        m_cnt = '0;
        m_el  = '0;
        m_ed  = '0;
        m_st  = 1'b0;
        sb_q.delete();
    endtask

    // Compare whenever pkt_cnt moves outside reset.
    logic [31:0] prev_cnt = '0;
    always @(negedge axis_aclk) begin
        exp_t e;
        if (axis_reset) begin
            prev_cnt = pkt_cnt;
        end else if (pkt_cnt !== prev_cnt) begin
            prev_cnt = pkt_cnt;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_pkt", 64'(pkt_cnt), 64'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("pkt_cnt", 64'(pkt_cnt), 64'(e.cnt));
                check("err_len_cnt", 64'(err_len_cnt), 64'(e.el));
                check("err_data_cnt", 64'(err_data_cnt), 64'(e.ed));
                check("err_sticky", 64'(err_sticky), 64'(e.st));
                check("done", 64'(done), 64'(e.dn));
            end
        end
    end

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k,
                              input logic [15:0] u, input logic l);
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = {$urandom, $urandom};
                @(posedge axis_aclk);
                #1;
            end
        end
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = {96'(0), 16'($urandom), u};
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        t = 0;
        @(negedge axis_aclk);
        while (!s_axis_tready && t < 1000) begin
            @(negedge axis_aclk);
            t++;
        end
        if (t >= 1000) check("tready_timeout", 64'd0, 64'd1);
        @(posedge axis_aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    // kind 0: normal; kind 1: extra tlast beat with tkeep=0;
    // kind 2: first beat tkeep=0x7F on a non-last beat (nbytes must exceed 8).
    task automatic send_pkt(input int nbytes, input int len_field, input int corrupt, input int kind);
        logic [7:0]  seq;
        logic [63:0] d;
        logic [7:0]  k;
        exp_t        e;
        int nbeats, total, cnt_bytes, idx;
        logic dbad, lbad;
        seq       = m_cnt[7:0];
        nbeats    = (nbytes + 7) / 8;
        total     = nbeats + ((kind == 1) ? 1 : 0);
        cnt_bytes = (kind == 2) ? nbytes - 1 : nbytes;
        dbad      = (corrupt >= 0 && corrupt < nbytes) || (kind == 2);
        lbad      = (cnt_bytes != len_field);
        m_cnt = m_cnt + 1;
        if (lbad && m_el != 16'hFFFF) m_el = m_el + 1;
        if (dbad && m_ed != 16'hFFFF) m_ed = m_ed + 1;
        if (lbad || dbad) m_st = 1'b1;
        e.cnt = m_cnt;
        e.el  = m_el;
        e.ed  = m_ed;
        e.st  = m_st;
        e.dn  = (m_cnt == expected_pkts) && (expected_pkts != 0);
        sb_q.push_back(e);
        for (int b = 0; b < total; b++) begin
            d = {$urandom, $urandom};
            k = '0;
            for (int i = 0; i < 8; i++) begin
                idx = b * 8 + i;
                if (b < nbeats && idx < nbytes) begin
                    k[i] = 1'b1;
                    d[8*i +: 8] = seq + 8'(idx);
                    if (idx == corrupt) d[8*i +: 8] = d[8*i +: 8] ^ 8'h55;
                end
            end
            if (kind == 2 && b == 0) k[7] = 1'b0;
            drive_beat(d, k, 16'(len_field), b == total - 1);
        end
    endtask

    task automatic do_reset(input int cycles);
        s_axis_tvalid = 1'b0;
        axis_reset    = 1'b1;
        repeat (cycles) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_err_len", 64'(err_len_cnt), 64'd0);
        check("rst_err_data", 64'(err_data_cnt), 64'd0);
        check("rst_sticky", 64'(err_sticky), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        model_reset();
        @(posedge axis_aclk);
        #1;
        axis_reset = 1'b0;
    endtask

    initial begin
        do_reset(3);
`ifndef CHK_BACKPRESSURE_EN
        @(negedge axis_aclk);
        check("tready_after_rst", 64'(s_axis_tready), 64'd1);
        @(posedge axis_aclk);
        #1;
`endif
        // Two good packets, then one with wrong length and a corrupted byte.
        send_pkt(16, 16, -1, 0);
        send_pkt(13, 13, -1, 0);
        send_pkt(16, 20, 5, 0);
        repeat (3) @(posedge axis_aclk);
        #1;

        // Reset after beat 1 of a 3-beat packet: partial packet is dropped.
        drive_beat({8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00},
                   8'hFF, 16'd24, 1'b0);
        do_reset(2);
        send_pkt(24, 24, -1, 0);

        // done after the third packet of a 3-packet run.
        expected_pkts = 32'd3;
        send_pkt(8, 8, -1, 0);
        @(negedge axis_aclk);
        check("done_before_third", 64'(done), 64'd0);
        @(posedge axis_aclk);
        #1;
        send_pkt(5, 5, -1, 0);
        // A fourth packet moves pkt_cnt past the target, so done drops.
        send_pkt(16, 16, -1, 1);
        send_pkt(12, 12, -1, 2);
        repeat (3) @(posedge axis_aclk);
        #1;

        // Random-length good packets with idle gaps (and stalls when enabled).
        do_reset(2);
        expected_pkts = 32'd100;
        gaps = 1'b1;
        for (int p = 0; p < 100; p++) begin
            int n;
            n = $urandom_range(1, 40);
            send_pkt(n, n, -1, 0);
        end
        repeat (4) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("final_pkt_cnt", 64'(pkt_cnt), 64'd100);
        check("final_errs", 64'({err_len_cnt, err_data_cnt}), 64'd0);
        check("final_done", 64'(done), 64'd1);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nf_axis_pkt_checker.md
NF_AXIS_PKT_CHECKER -- requirements
Module: nf_axis_pkt_checker

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 64, meaning data bus width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, meaning sideband width; bits [15:0] carry packet length in bytes.
REQ-003 SHALL have parameter C_CNT_WIDTH, default 32, meaning width of the packet counter and the expected-count input.
REQ-004 SHALL have port axis_aclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port axis_reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have ports s_axis_tdata (input, C_S_AXIS_DATA_WIDTH), s_axis_tkeep (input, C_S_AXIS_DATA_WIDTH/8), s_axis_tuser (input, C_S_AXIS_TUSER_WIDTH), s_axis_tvalid (input, 1) and s_axis_tlast (input, 1): the AXI4-Stream slave.
REQ-007 SHALL have port s_axis_tready, output, 1 bit: stream backpressure.
REQ-008 SHALL have port expected_pkts, input, C_CNT_WIDTH: number of packets for the test run.
REQ-009 SHALL have outputs pkt_cnt (C_CNT_WIDTH), err_len_cnt (16), err_data_cnt (16), err_sticky (1) and done (1).

Function
REQ-010 SHALL count a beat only on the cycle where tvalid and tready are both high; when tvalid is high and tready is low, input changes SHALL be ignored.
REQ-011 SHALL implement the FSM IDLE->BODY on an accepted first beat with tlast=0, BODY->IDLE on an accepted beat with tlast=1, and stay in IDLE on a single-beat packet.
REQ-012 SHALL latch tuser[15:0] as the expected length on the first beat of each packet and ignore tuser on later beats.
REQ-013 SHALL generate expected payload byte k (k counted from 0 across the whole packet) as (seq[7:0] + k) mod 256, where seq is the current pkt_cnt value.
REQ-014 SHALL compare only bytes whose tkeep bit is set; any mismatch marks the packet data-bad.
REQ-015 SHALL mark a packet data-bad if tkeep is not contiguous from the LSB, or if tkeep is not all-ones on a non-last beat.
REQ-016 SHALL accumulate the byte count as the popcount of tkeep; at tlast, a count different from the latched length marks the packet length-bad.
REQ-017 SHALL, one cycle after the tlast handshake, increment pkt_cnt, increment err_len_cnt if the packet is length-bad, increment err_data_cnt if it is data-bad (both may increment for the same packet), and set err_sticky if either counter incremented.
REQ-018 SHALL saturate err_len_cnt and err_data_cnt at 0xFFFF; pkt_cnt SHALL wrap modulo 2^C_CNT_WIDTH.
REQ-019 SHALL raise done, registered, when pkt_cnt equals expected_pkts and expected_pkts is non-zero; done SHALL fall if pkt_cnt later advances past that value.
REQ-020 SHALL count a packet whose tlast beat has all-zero tkeep normally, treating that beat as contributing 0 bytes.

Reset
REQ-021 SHALL, while axis_reset is high, force the FSM to IDLE and clear pkt_cnt, err_len_cnt, err_data_cnt, err_sticky, done and all per-packet state.
REQ-022 SHALL hold s_axis_tready at 0 while in reset.
REQ-023 SHALL, when reset occurs mid-packet, discard the partial packet without counting it; after reset, the next accepted beat is the first beat of a packet.

Configuration
REQ-024 SHALL, when CHK_BACKPRESSURE_EN is defined, drive s_axis_tready from bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset; advances every cycle).
REQ-025 SHALL, when CHK_BACKPRESSURE_EN is undefined, hold s_axis_tready at 1 whenever reset is low, and omit the LFSR.

Structure
REQ-026 SHALL place the FSM state encoding, the LFSR seed and tap constants, and the tuser length field bounds in the shared package nf_axis_chk_pkg.
REQ-027 SHALL implement the keep-to-byte-count popcount and the contiguity check as the sub-module nf_axis_keep_count, which is purely combinational.

Verification
REQ-028 SHALL cover: reset, then one 16-byte packet (2 beats, tuser=16, bytes 0x00..0x0F, tkeep 0xFF/0xFF) -> pkt_cnt=1, both error counters 0, err_sticky=0.
REQ-029 SHALL cover: packet 2 (seq=1) sent with 13 bytes (tkeep 0xFF/0x1F), tuser=13, bytes 0x01..0x0D -> pkt_cnt=2, no errors.
REQ-030 SHALL cover: 16-byte packet with tuser=20 and byte 5 corrupted -> err_len_cnt=1, err_data_cnt=1, err_sticky=1 on the cycle after tlast.
REQ-031 SHALL cover: expected_pkts=3 with three good packets sent -> done rises one cycle after the third tlast handshake.
REQ-032 SHALL cover: axis_reset asserted after beat 1 of a 3-beat packet -> all counters 0 and tready=0 during reset; the next full packet with seq=0 counts as good.
REQ-033 SHALL cover: with CHK_BACKPRESSURE_EN defined, 100 random-length good packets while tvalid is held steady during stalls -> pkt_cnt=100, zero errors.
